// File: rtl/cmd_write.sv
// SD host CMD-line transmitter: serialises start, direction, index, argument, CRC7 and end bit.
// Optional macro CMD_WRITE_NCC_GAP_EN holds the block busy for NccCycles bit periods after each frame.
module cmd_write #(
  parameter int unsigned NccCycles = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clk_en_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        start_listening_o,
  output logic        cmd_o,
  output logic        cmd_en_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
`ifdef CMD_WRITE_NCC_GAP_EN
  localparam logic [1:0] GAP     = 2'd3;
  localparam int unsigned GapW = (NccCycles > 1) ? $clog2(NccCycles) : 1;

  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  logic [1:0]  state_q, state_d;
  logic [39:0] shift_q, shift_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [6:0]  crc_q, crc_d;
  logic        cmd_q, cmd_d;
  logic        cmd_en_q, cmd_en_d;
  logic        pulse_q, pulse_d;
  logic        tx_bit;
  logic        crc_fb;

  // Bit on the wire for the current counter value: header, then CRC, then end bit.
  always_comb begin
    if (cnt_q < 6'd40) begin
      tx_bit = shift_q[39];
    end else if (cnt_q < 6'd47) begin
      tx_bit = crc_q[6];
    end else begin
      tx_bit = 1'b1;
    end
    crc_fb = tx_bit ^ crc_q[6];
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    cmd_d    = cmd_q;
    cmd_en_d = cmd_en_q;
    pulse_d  = 1'b0;
`ifdef CMD_WRITE_NCC_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        cmd_d    = 1'b1;
        cmd_en_d = 1'b0;
        if (start_i) begin
          shift_d = {2'b01, cmd_index_i, cmd_arg_i};
          cnt_d   = 6'd0;
          crc_d   = 7'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (clk_en_i) begin
          cmd_d    = tx_bit;
          cmd_en_d = 1'b1;
          cnt_d    = cnt_q + 6'd1;
          // CRC7 (x^7 + x^3 + 1) absorbs header bits, then is shifted out MSB first.
          if (cnt_q < 6'd40) begin
            shift_d = {shift_q[38:0], 1'b0};
            crc_d   = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
          end else if (cnt_q < 6'd47) begin
            crc_d = {crc_q[5:0], 1'b0};
          end
          if (cnt_q == 6'd47) begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (clk_en_i) begin
          cmd_d    = 1'b1;
          cmd_en_d = 1'b0;
          pulse_d  = 1'b1;
`ifdef CMD_WRITE_NCC_GAP_EN
          gap_cnt_d = '0;
          state_d   = GAP;
`else
          state_d   = IDLE;
`endif
        end
      end
`ifdef CMD_WRITE_NCC_GAP_EN
      GAP: begin
        cmd_d    = 1'b1;
        cmd_en_d = 1'b0;
        if (clk_en_i) begin
          if (gap_cnt_q == GapW'(NccCycles - 1)) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d  = IDLE;
        cmd_d    = 1'b1;
        cmd_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      crc_q    <= '0;
      cmd_q    <= 1'b1;
      cmd_en_q <= 1'b0;
      pulse_q  <= 1'b0;
`ifdef CMD_WRITE_NCC_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      cmd_q    <= cmd_d;
      cmd_en_q <= cmd_en_d;
      pulse_q  <= pulse_d;
`ifdef CMD_WRITE_NCC_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign ready_o           = (state_q == IDLE);
  assign busy_o            = ~ready_o;
  assign done_o            = pulse_q;
  assign start_listening_o = pulse_q;
  assign cmd_o             = cmd_q;
  assign cmd_en_o          = cmd_en_q;

endmodule

// File: tb/tb_cmd_write.sv
// Self-checking bench for cmd_write: frame-level reference model compared every cycle,
// plus literal frame values for the standard CMD0/CMD8/CMD17 frames.
module tb_cmd_write;

  localparam int unsigned NCC = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        clk_en_i = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  cmd_index_i = '0;
  logic [31:0] cmd_arg_i = '0;
  logic        ready_o, busy_o, done_o, start_listening_o, cmd_o, cmd_en_o;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;
  int enDiv = 1;
  int cyc = 0;

  // Reference model state: pos = -1 idle, 0..47 next frame bit, 48 release pending, -2 gap
  int          pos = -1;
  logic [47:0] mFrame = '0;
  logic        mCmd = 1'b1;
  logic        mEn = 1'b0;
  logic        mPulse = 1'b0;
`ifdef CMD_WRITE_NCC_GAP_EN
  int          gapLeft = 0;
`endif

  // Monitor state, written only by the negedge process
  bit          enEdge = 1'b0;
  logic [47:0] cap = '0;
  int          capCnt = 0;
  int          enCycles = 0;
  int          doneCnt = 0;

  // Snapshots, written only by the stimulus process
  int snapCap = 0;
  int snapEn = 0;
  int snapDone = 0;

  cmd_write #(.NccCycles(NCC)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .clk_en_i(clk_en_i),
    .start_i(start_i),
    .cmd_index_i(cmd_index_i),
    .cmd_arg_i(cmd_arg_i),
    .ready_o(ready_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .start_listening_o(start_listening_o),
    .cmd_o(cmd_o),
    .cmd_en_o(cmd_en_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] makeFrame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    logic [6:0]  crc;
    logic        fb;
    hdr = {2'b01, idx, arg};
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = hdr[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return {hdr, crc, 1'b1};
  endfunction

  // Enable generator: one pulse every enDiv clocks
  always begin
    @(posedge clk);
    #2;
    cyc++;
    clk_en_i = (enDiv <= 1) || ((cyc % enDiv) == 0);
  end

  // Frame-level model: a request loads a 48-bit frame, each enable emits the next bit
  always @(posedge clk) begin
    enEdge = clk_en_i && !rst_i;
    if (rst_i) begin
      pos = -1; mCmd = 1'b1; mEn = 1'b0; mPulse = 1'b0;
    end else begin
      mPulse = 1'b0;
      if (pos == -1) begin
        if (start_i) begin
          mFrame = makeFrame(cmd_index_i, cmd_arg_i);
          pos = 0;
        end
      end else if (clk_en_i) begin
        if (pos >= 0 && pos < 48) begin
          mCmd = mFrame[47 - pos];
          mEn = 1'b1;
          pos++;
        end else if (pos == 48) begin
          mCmd = 1'b1;
          mEn = 1'b0;
          mPulse = 1'b1;
`ifdef CMD_WRITE_NCC_GAP_EN
          pos = -2;
          gapLeft = NCC;
`else
          pos = -1;
`endif
        end
`ifdef CMD_WRITE_NCC_GAP_EN
        else begin
          gapLeft--;
          if (gapLeft == 0) pos = -1;
        end
`endif
      end
    end
  end

  // Per-cycle comparison and frame capture
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("cmd_o", cmd_o, mCmd);
      checkOutput("cmd_en_o", cmd_en_o, mEn);
      checkOutput("ready_o", ready_o, pos == -1);
      checkOutput("busy_o", busy_o, pos != -1);
      checkOutput("done_o", done_o, mPulse);
      checkOutput("start_listening_o", start_listening_o, mPulse);
      if (enEdge && cmd_en_o) begin
        cap = {cap[46:0], cmd_o};
        capCnt++;
      end
      if (cmd_en_o) enCycles++;
      if (done_o) doneCnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (ready_o !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    checkOutput({name, "_ready"}, ready_o, 1'b1);
  endtask

  task automatic snap();
    snapCap = capCnt;
    snapEn = enCycles;
    snapDone = doneCnt;
  endtask

  task automatic applyStimulus(input string name, input logic [5:0] idx, input logic [31:0] arg, input bit midStart);
    waitReady(name);
    snap();
    cmd_index_i = idx;
    cmd_arg_i = arg;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    cmd_index_i = 6'h3F;
    cmd_arg_i = 32'hDEADBEEF;
    if (midStart) begin
      repeat (20) step();
      start_i = 1'b1;
      cmd_index_i = 6'd5;
      step();
      start_i = 1'b0;
    end
  endtask

  task automatic finishFrame(input string name, input logic [47:0] expFrame, input bit chain);
    int n = 0;
    while (done_o !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    checkOutput({name, "_done_seen"}, done_o, 1'b1);
    if (chain) begin
      start_i = 1'b1;
      cmd_index_i = 6'd0;
      cmd_arg_i = 32'd0;
    end
    step();
    start_i = 1'b0;
    step();
    checkOutput({name, "_bit_count"}, capCnt - snapCap, 48);
    checkOutput({name, "_frame"}, cap, expFrame);
    checkOutput({name, "_en_cycles"}, enCycles - snapEn, 48 * enDiv);
    checkOutput({name, "_done_pulses"}, doneCnt - snapDone, 1);
    if (chain) snap();
  endtask

  initial begin
    $display("[TB] cmd_write bench start");
    rst_i = 1'b1;
    step();
    step();
    checkOn = 1'b1;
    checkOutput("rst_ready", ready_o, 1'b1);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_done", done_o, 1'b0);
    checkOutput("rst_listen", start_listening_o, 1'b0);
    checkOutput("rst_cmd", cmd_o, 1'b1);
    checkOutput("rst_cmd_en", cmd_en_o, 1'b0);
    checkOutput("model_cmd0", makeFrame(6'd0, 32'h0), 48'h400000000095);
    checkOutput("model_cmd8", makeFrame(6'd8, 32'h1AA), 48'h48000001AA87);
    checkOutput("model_cmd17", makeFrame(6'd17, 32'h0), 48'h510000000055);
    rst_i = 1'b0;
    step();

    enDiv = 1;
    applyStimulus("cmd0", 6'd0, 32'h0, 1'b0);
    finishFrame("cmd0", 48'h400000000095, 1'b0);

    enDiv = 4;
    applyStimulus("cmd8", 6'd8, 32'h1AA, 1'b0);
    finishFrame("cmd8", 48'h48000001AA87, 1'b0);
    enDiv = 1;

`ifdef CMD_WRITE_NCC_GAP_EN
    applyStimulus("cmd17", 6'd17, 32'h0, 1'b1);
    finishFrame("cmd17", 48'h510000000055, 1'b0);
    checkOutput("gap_ready_low", ready_o, 1'b0);
    start_i = 1'b1;
    cmd_index_i = 6'd17;
    step();
    start_i = 1'b0;
    checkOutput("gap_start_ignored", ready_o, 1'b0);
    applyStimulus("cmd0_after_gap", 6'd0, 32'h0, 1'b0);
    finishFrame("cmd0_after_gap", 48'h400000000095, 1'b0);
`else
    applyStimulus("cmd17", 6'd17, 32'h0, 1'b1);
    finishFrame("cmd17", 48'h510000000055, 1'b1);
    finishFrame("cmd0_b2b", 48'h400000000095, 1'b0);
`endif

    // Reset in the middle of a CMD8 frame
    applyStimulus("cmd8_rst", 6'd8, 32'h1AA, 1'b0);
    begin
      int n = 0;
      while ((capCnt - snapCap) < 20 && n < 400) begin
        step();
        n++;
      end
      checkOutput("rst_mid_reached", capCnt - snapCap, 20);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checkOutput("midrst_cmd", cmd_o, 1'b1);
    checkOutput("midrst_cmd_en", cmd_en_o, 1'b0);
    checkOutput("midrst_ready", ready_o, 1'b1);
    checkOutput("midrst_done", done_o, 1'b0);
    repeat (60) step();
    checkOutput("midrst_no_pulse", doneCnt - snapDone, 0);
    applyStimulus("cmd0_after_rst", 6'd0, 32'h0, 1'b0);
    finishFrame("cmd0_after_rst", 48'h400000000095, 1'b0);

    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cmd_write.md
# cmd_write

Transmits SD host commands on the CMD line: a 48-bit frame of start bit, transmission bit, 6-bit index, 32-bit argument, CRC7 and end bit.
- Sits between the command-issue control logic and the CMD pad.
- Counterpart of the response receiver: after the end bit it pulses that receiver's `start_listening` input at the required point.
- Generates CRC7 internally; all bit updates are qualified by the SD clock enable.

## Interface
- `NccCycles`, default 8: idle SD bit periods enforced after the end bit (used only with `CMD_WRITE_NCC_GAP_EN`).
- `clk_i`  in  1  system clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clk_en_i`  in  1  SD clock enable; one pulse = one CMD bit period.
- `start_i`  in  1  request; accepted only while `ready_o`=1.
- `cmd_index_i`  in  6  command index, sampled on acceptance.
- `cmd_arg_i`  in  32  argument, sampled on acceptance.
- `ready_o`  out  1  idle, can accept a request.
- `busy_o`  out  1  frame in progress (`~ready_o`).
- `done_o`  out  1  one-cycle pulse: frame completed.
- `start_listening_o`  out  1  one-cycle pulse to the response receiver.
- `cmd_o`  out  1  serial CMD data (registered); 1 when not driving.
- `cmd_en_o`  out  1  CMD output enable (registered).

## Operation
- States: IDLE, SEND, RELEASE, GAP (GAP exists only with the macro).
- IDLE: `ready_o`=1, `cmd_o`=1, `cmd_en_o`=0.
  - On `start_i`: latch {0, 1, index, arg} into a 40-bit shift register, clear the 6-bit bit counter and the CRC, go to SEND.
  - Acceptance does not need `clk_en_i`.
- SEND, on each `clk_en_i` cycle: `cmd_o` <= bit[cnt], `cmd_en_o` <= 1, cnt++.
  - cnt 0..39: shift-register MSB; the same bit feeds the CRC7 (poly x^7+x^3+1).
  - cnt 40..46: CRC MSB first; the CRC register shifts with 0 fed in.
  - cnt 47: end bit 1; then go to RELEASE.
- RELEASE, on the next `clk_en_i` cycle:
  - `cmd_o` <= 1, `cmd_en_o` <= 0.
  - `done_o` and `start_listening_o` pulse for exactly one `clk_i` cycle, the cycle after that edge.
  - Next state: IDLE, or GAP if the macro is defined.
- `start_i` while busy is ignored; it is not queued.
- Index and argument changes after acceptance have no effect.
- Reset (any state, mid-frame included): next edge gives IDLE, `cmd_o`=1, `cmd_en_o`=0, counter/CRC/shift register = 0, pulses = 0.
- `rst_i` has priority over `start_i`.

## Timing
- Reset values: `ready_o`=1, `busy_o`=0, `done_o`=0, `start_listening_o`=0, `cmd_o`=1, `cmd_en_o`=0.
- Accept at edge k. With `clk_en_i` held high:
  - start bit on `cmd_o` after edge k+1; bit i after edge k+1+i.
  - end bit after edge k+48.
  - line released after edge k+49.
  - pulses and `ready_o`=1 after edge k+49 (no macro).
- With gated `clk_en_i`: `cmd_o` is stable between enable pulses. Each bit lasts exactly one enable period; no bit is skipped or duplicated.
- `clk_en_i` low in the acceptance cycle: no effect on framing.
- Back-to-back requests (no macro): `start_i` high the cycle `ready_o` rises is accepted. Minimum inter-frame idle is one bit period.

## Configuration
- `CMD_WRITE_NCC_GAP_EN` defined:
  - after RELEASE, enter GAP; `ready_o`=0 until `NccCycles` further `clk_en_i` pulses have elapsed, `cmd_o`=1.
  - `done_o`/`start_listening_o` still pulse at RELEASE.
- Undefined: GAP state and its counter are not compiled; RELEASE returns directly to IDLE.

## Test plan
- CMD0, arg 0x00000000, `clk_en_i`=1 -> `cmd_o` serialises 0x400000000095 MSB first over 48 enables; `cmd_en_o`=1 exactly those 48 cycles.
- CMD8, arg 0x000001AA, `clk_en_i` every 4th cycle -> frame 0x48000001AA87; each bit held 4 cycles; `done_o` single pulse.
- CMD17, arg 0 -> frame 0x510000000055. `start_i` re-asserted mid-frame is ignored; after `done_o`, a second CMD0 frame follows.
- `rst_i` at bit 20 of CMD8 -> next cycle `cmd_o`=1, `cmd_en_o`=0, `ready_o`=1, no pulses; a new CMD0 is then bit-exact.
- `start_listening_o` timing -> exactly one pulse, coincident with `done_o`, one cycle after the release edge.
- Macro on, `NccCycles`=8 -> `ready_o` stays 0 for 8 enables after release; `start_i` in that window is ignored.
